// File: rtl/comparator_serial.sv
// rtl/comparator_serial.sv - chunk-serial equal / signed-lt / unsigned-lt comparator
// Optional macro COMPARATOR_SERIAL_EARLY_EXIT_EN: finish on the first differing chunk.
module comparator_serial #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         equals,
  output logic         less_than,
  output logic         less_than_u
);

  localparam int NCHUNK = N / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((CHUNK < 1) || (CHUNK > N)) begin : g_bad_chunk
    $error("comparator_serial: CHUNK must satisfy 1 <= CHUNK <= N");
  end
  if ((N % CHUNK) != 0) begin : g_bad_div
    $error("comparator_serial: N must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           decided_q, decided_d;
  logic           ltu_r_q, ltu_r_d;
  logic           sdiff_q, sdiff_d;
  logic           out_valid_q, out_valid_d;
  logic           equals_q, equals_d;
  logic           less_than_q, less_than_d;
  logic           less_than_u_q, less_than_u_d;

  // Operands split into chunks, index 0 holding the most significant bits.
  logic [CHUNK-1:0] a_chunks [NCHUNK];
  logic [CHUNK-1:0] b_chunks [NCHUNK];
  for (genvar i = 0; i < NCHUNK; i++) begin : g_chunks
    assign a_chunks[i] = a_q[N-1-i*CHUNK -: CHUNK];
    assign b_chunks[i] = b_q[N-1-i*CHUNK -: CHUNK];
  end

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_diff, chunk_ltu, last_chunk, run_finish;
  logic             decided_nx, ltu_nx;

  assign a_chunk    = a_chunks[k_q];
  assign b_chunk    = b_chunks[k_q];
  assign chunk_diff = (a_chunk != b_chunk);
  assign chunk_ltu  = (a_chunk < b_chunk);
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  // Only the first differing chunk decides the magnitude order.
  assign decided_nx = decided_q | chunk_diff;
  assign ltu_nx     = (!decided_q && chunk_diff) ? chunk_ltu : ltu_r_q;

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
  assign run_finish = last_chunk | (!decided_q && chunk_diff);
`else
  assign run_finish = last_chunk;
`endif

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign out_valid   = out_valid_q;
  assign equals      = equals_q;
  assign less_than   = less_than_q;
  assign less_than_u = less_than_u_q;

  // Next-state and datapath updates for the IDLE/RUN/DONE handshake sequence.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    a_d           = a_q;
    b_d           = b_q;
    decided_d     = decided_q;
    ltu_r_d       = ltu_r_q;
    sdiff_d       = sdiff_q;
    out_valid_d   = out_valid_q;
    equals_d      = equals_q;
    less_than_d   = less_than_q;
    less_than_u_d = less_than_u_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          k_d       = '0;
          decided_d = 1'b0;
          ltu_r_d   = 1'b0;
          sdiff_d   = a[N-1] ^ b[N-1];
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        decided_d = decided_nx;
        ltu_r_d   = ltu_nx;
        k_d       = k_q + KW'(1);
        if (run_finish) begin
          state_d       = S_DONE;
          out_valid_d   = 1'b1;
          equals_d      = !decided_nx;
          less_than_u_d = ltu_nx;
          // Opposite signs settle the signed order from a's sign bit alone.
          less_than_d   = sdiff_q ? a_q[N-1] : ltu_nx;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      decided_q     <= 1'b0;
      ltu_r_q       <= 1'b0;
      sdiff_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      equals_q      <= 1'b0;
      less_than_q   <= 1'b0;
      less_than_u_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      a_q           <= a_d;
      b_q           <= b_d;
      decided_q     <= decided_d;
      ltu_r_q       <= ltu_r_d;
      sdiff_q       <= sdiff_d;
      out_valid_q   <= out_valid_d;
      equals_q      <= equals_d;
      less_than_q   <= less_than_d;
      less_than_u_q <= less_than_u_d;
    end
  end

endmodule

// File: doc/comparator_serial.md
Name: comparator_serial

Overview:
Parametrised, multi-cycle successor to the combinational comparator_eq/comparator_lt pair. It accepts one operand pair through a valid/ready handshake and compares the pair CHUNK bits per cycle, most significant chunk first. It returns all three relations together: equal, signed less-than and unsigned less-than. It serves ALU/branch paths that trade latency for a narrow per-cycle compare datapath.

Parameters:
N, 32, operand width in bits; N % CHUNK must be 0, otherwise elaboration fails with $error.
CHUNK, 8, bits compared per cycle; must satisfy 1 <= CHUNK <= N. NCHUNK = N/CHUNK.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset: synchronous, active-high.
in_valid  input  1  operand pair on a/b is valid.
in_ready  output  1  block can accept a pair; high only in IDLE.
a  input  N  operand A, two's complement when read as signed.
b  input  N  operand B.
out_valid  output  1  result flags are valid.
out_ready  input  1  consumer accepts the result.
equals  output  1  a == b.
less_than  output  1  signed a < b.
less_than_u  output  1  unsigned a < b.

Behaviour:
- State machine states: IDLE, RUN, DONE. Chunk index k counts 0..NCHUNK-1; chunk k = bits [N-1-k*CHUNK -: CHUNK].
- Reset (rst high at a clock edge): state goes to IDLE; k, out_valid, equals, less_than and less_than_u all clear to 0. in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Reset mid-operation: the operation is abandoned and no result is produced.
- IDLE:
  - in_ready = 1.
  - on the edge where in_valid & in_ready: register a and b, clear k and the "decided" flag, record sdiff = a[N-1] ^ b[N-1], go to RUN.
- RUN, one edge per chunk:
  - if not yet decided and chunk k differs: set decided, ltu_r = (a_chunk < b_chunk) unsigned.
  - k increments; after the edge that processes k = NCHUNK-1, go to DONE.
- Result latency: out_valid rises NCHUNK edges after the accepting edge (4 for the defaults).
- Entering DONE, the outputs are set as follows:
  - equals = !decided.
  - less_than_u = ltu_r.
  - less_than = sdiff ? a_reg[N-1] : ltu_r.
- DONE:
  - out_valid = 1; the flags hold stable while out_valid & !out_ready.
  - in_ready = 0; there is no accept/complete bypass.
  - on the edge with out_ready: out_valid goes to 0 and state goes to IDLE.
- Throughput: one pair every NCHUNK+2 cycles when out_ready is held high.
- Flags are registered outputs and are don't-care when out_valid = 0; they retain their last value until the next DONE.
- in_valid while not in IDLE is ignored. a and b may change after the accepting edge without effect.
- CHUNK = N: single-cycle RUN, latency 1.
- Edge values:
  - a = b = all ones: equals = 1.
  - a = 0x80000000, b = 0x7FFFFFFF: sdiff = 1, so less_than = 1 and less_than_u = 0.

Optional Feature:
Macro COMPARATOR_SERIAL_EARLY_EXIT_EN.
- Defined: in RUN, the first differing chunk moves the block to DONE on that same edge, so latency = (index of first differing chunk) + 1. Equal operands still take NCHUNK cycles.
- Undefined: latency is always exactly NCHUNK cycles, independent of the data.
- Result values are identical in both builds.

Test Plan:
1. N=32, CHUNK=8, a=0x00000000, b=0x00000000, out_ready=1 -> out_valid exactly 4 cycles after accept; equals=1, less_than=0, less_than_u=0; in_ready high again on the following cycle.
2. a=0xFFFFFFFF (-1), b=0x00000001 -> equals=0, less_than=1, less_than_u=0. Swapped (a=1, b=-1) -> less_than=0, less_than_u=1.
3. a=0x80000000, b=0x7FFFFFFF -> less_than=1, less_than_u=0. Latency is 1 cycle with COMPARATOR_SERIAL_EARLY_EXIT_EN and 4 cycles without it.
4. a=0x12345678, b=0x12345679 -> equals=0, less_than=1, less_than_u=1. Latency is 4 cycles in both builds, because the only difference is in the last chunk.
5. Backpressure: complete a=38273, b=38273 with out_ready=0 for 5 cycles.
   -> out_valid and equals=1 held stable, in_ready=0 throughout, and a new in_valid is ignored.
   -> raise out_ready: out_valid falls after that edge and in_ready=1 on the next cycle.
6. Assert rst for 1 cycle during RUN (k=2) -> out_valid never rises for that pair; in_ready=1 the cycle after rst falls. A new pair a=5, b=3 then yields less_than=0, less_than_u=0 at normal latency.
